// File: rtl/vga_bar_pkg.sv
// rtl/vga_bar_pkg.sv - shared colour constants, column-FSM state type and width helpers
package vga_bar_pkg;

    localparam int RGB_W    = 12;
    localparam int HEIGHT_W = 12;

    localparam logic [RGB_W-1:0] POS_COLOR_DEF  = 12'hF00;
    localparam logic [RGB_W-1:0] NEG_COLOR_DEF  = 12'h0F0;
    localparam logic [RGB_W-1:0] AXIS_COLOR_DEF = 12'hFFF;
    localparam logic [RGB_W-1:0] BG_COLOR_DEF   = 12'h00F;

    typedef enum logic [1:0] {
        COL_LEFT  = 2'd0,
        COL_BAR   = 2'd1,
        COL_GAP   = 2'd2,
        COL_RIGHT = 2'd3
    } col_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_bar_renderer_if.sv
// rtl/weight_bar_renderer_if.sv - weight load handshake bundle
interface weight_bar_renderer_if #(
    parameter int NUM_BARS = 8,
    parameter int VAL_W    = 10
) ();

    logic [NUM_BARS*VAL_W-1:0] weights_flat;
    logic                      weights_valid;
    logic                      weights_ready;

    modport master (
        output weights_flat,
        output weights_valid,
        input  weights_ready
    );

    modport slave (
        input  weights_flat,
        input  weights_valid,
        output weights_ready
    );

endinterface

// File: rtl/bar_column_tracker.sv
// rtl/bar_column_tracker.sv - follows counter_x across the bar strip; outputs describe
// the pixel sampled on the most recent clock edge.
module bar_column_tracker
    import vga_bar_pkg::*;
#(
    parameter int NUM_BARS = 8,
    parameter int X0       = 101,
    parameter int PITCH    = 60,
    parameter int BAR_W    = 4,
    parameter int IDX_W    = idx_width(NUM_BARS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [9:0]       counter_x,
    output logic             in_bar,
    output logic [IDX_W-1:0] idx,
    output logic             in_region
);

    localparam int               POS_W      = $clog2(PITCH);
    localparam logic [9:0]       X0_X       = 10'(X0);
    localparam logic [POS_W-1:0] BAR_LAST   = POS_W'(BAR_W - 1);
    localparam logic [POS_W-1:0] PITCH_LAST = POS_W'(PITCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BARS - 1);

    col_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        if (counter_x == 10'd0) begin
            state_d = COL_LEFT;
            idx_d   = '0;
            pos_d   = '0;
        end else if (counter_x == X0_X) begin
            state_d = COL_BAR;
            idx_d   = '0;
            pos_d   = '0;
        end else begin
            case (state_q)
                COL_BAR: begin
                    pos_d = pos_q + 1'b1;
                    if (pos_q == BAR_LAST) begin
                        state_d = COL_GAP;
                    end
                end
                COL_GAP: begin
                    if (pos_q == PITCH_LAST) begin
                        pos_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = COL_RIGHT;
                        end else begin
                            state_d = COL_BAR;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= COL_LEFT;
            idx_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
        end
    end

    assign in_bar    = (state_q == COL_BAR);
    assign in_region = (state_q == COL_BAR) || (state_q == COL_GAP);
    assign idx       = idx_q;

endmodule

// File: rtl/weight_bar_renderer.sv
// rtl/weight_bar_renderer.sv - draws signed weights as vertical bars about a baseline;
// double-buffered weight banks swap only at frame_start, colour out two cycles after sampling.
module weight_bar_renderer
    import vga_bar_pkg::*;
#(
    parameter int NUM_BARS  = 8,
    parameter int VAL_W     = 10,
    parameter int X0        = 101,
    parameter int PITCH     = 60,
    parameter int BAR_W     = 4,
    parameter int BASELINE  = 241,
    parameter int MAX_H     = 200,
    parameter logic [RGB_W-1:0] POS_COLOR  = POS_COLOR_DEF,
    parameter logic [RGB_W-1:0] NEG_COLOR  = NEG_COLOR_DEF,
    parameter logic [RGB_W-1:0] AXIS_COLOR = AXIS_COLOR_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR   = BG_COLOR_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [9:0]           counter_x,
    input  logic [9:0]           counter_y,
    input  logic                 frame_start,
    weight_bar_renderer_if.slave wif,
    output logic [RGB_W-1:0]     out_color
);

    localparam int FLAT_W = NUM_BARS * VAL_W;
    localparam int IDX_W  = idx_width(NUM_BARS);
    localparam logic signed [HEIGHT_W-1:0] BASE_S = HEIGHT_W'(BASELINE);

    logic [FLAT_W-1:0] shadow_q, shadow_d;
    logic [FLAT_W-1:0] active_q, active_d;
    logic              pending_q, pending_d;
    logic              xfer;

    logic             in_bar, in_region;
    logic [IDX_W-1:0] bar_idx;
    logic [9:0]       y1_q, y1_d;

    logic                 b_region_q, b_region_d;
    logic                 b_pos_q, b_pos_d;
    logic                 b_neg_q, b_neg_d;
    logic [9:0]           b_y_q, b_y_d;
    logic [HEIGHT_W-1:0]  b_mag_q, b_mag_d;
    logic [RGB_W-1:0]     out_color_q, out_color_d;

    logic [VAL_W-1:0]          v_sel;
    logic signed [VAL_W:0]     v_ext, abs_v;
    logic signed [HEIGHT_W-1:0] y_s, top_s, bot_s;

    bar_column_tracker #(
        .NUM_BARS (NUM_BARS),
        .X0       (X0),
        .PITCH    (PITCH),
        .BAR_W    (BAR_W),
        .IDX_W    (IDX_W)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .counter_x (counter_x),
        .in_bar    (in_bar),
        .idx       (bar_idx),
        .in_region (in_region)
    );

    assign wif.weights_ready = ~pending_q;
    assign xfer              = wif.weights_valid & ~pending_q;

    // A swap and a fresh load can never coincide: a load needs pending low, a swap needs it high.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame_start && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (xfer) begin
            shadow_d  = wif.weights_flat;
            pending_d = 1'b1;
        end
    end

    assign y1_d = counter_y;

    // Stage B: pick this bar's weight and reduce it to a clipped height plus direction.
    always_comb begin
        v_sel = '0;
        for (int k = 0; k < NUM_BARS; k++) begin
            if (bar_idx == IDX_W'(k)) begin
                v_sel = active_q[k*VAL_W +: VAL_W];
            end
        end
        v_ext = {v_sel[VAL_W-1], v_sel};
        abs_v = v_ext[VAL_W] ? -v_ext : v_ext;
        if (32'(abs_v) > MAX_H) begin
            b_mag_d = HEIGHT_W'(MAX_H);
        end else begin
            b_mag_d = HEIGHT_W'(abs_v);
        end
        b_pos_d    = in_bar && !v_sel[VAL_W-1] && (v_sel != '0);
        b_neg_d    = in_bar && v_sel[VAL_W-1];
        b_region_d = in_region;
        b_y_d      = y1_q;
    end

    // Stage C: signed row compare so BASELINE +/- MAX_H cannot wrap.
    always_comb begin
        y_s   = signed'(HEIGHT_W'(b_y_q));
        top_s = BASE_S - signed'(b_mag_q);
        bot_s = BASE_S + signed'(b_mag_q);
        out_color_d = BG_COLOR;
        if (b_region_q && (y_s == BASE_S)) begin
            out_color_d = AXIS_COLOR;
        end
        if (b_pos_q && (y_s >= top_s) && (y_s < BASE_S)) begin
            out_color_d = POS_COLOR;
        end
        if (b_neg_q && (y_s > BASE_S) && (y_s <= bot_s)) begin
            out_color_d = NEG_COLOR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            y1_q        <= '0;
            b_region_q  <= 1'b0;
            b_pos_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            b_y_q       <= '0;
            b_mag_q     <= '0;
            out_color_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            y1_q        <= y1_d;
            b_region_q  <= b_region_d;
            b_pos_q     <= b_pos_d;
            b_neg_q     <= b_neg_d;
            b_y_q       <= b_y_d;
            b_mag_q     <= b_mag_d;
            out_color_q <= out_color_d;
        end
    end

    assign out_color = out_color_q;

endmodule

// File: tb/tb_weight_bar_renderer.sv
// tb/tb_weight_bar_renderer.sv - randomized scoreboard bench for weight_bar_renderer
module tb_weight_bar_renderer;

    localparam int NB = 8, VW = 10, X0 = 101, P = 60, BW = 4, BASE = 241, MAXH = 200;
    localparam int LINE = 640;
    localparam logic [11:0] POS_C = 12'hF00, NEG_C = 12'h0F0, AXIS_C = 12'hFFF, BG_C = 12'h00F;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  counter_x = '0;
    logic [9:0]  counter_y = '0;
    logic        frame_start = 1'b0;
    logic [11:0] out_color;

    weight_bar_renderer_if #(.NUM_BARS(NB), .VAL_W(VW)) wif ();

    weight_bar_renderer #(
        .NUM_BARS(NB), .VAL_W(VW), .X0(X0), .PITCH(P), .BAR_W(BW),
        .BASELINE(BASE), .MAX_H(MAXH),
        .POS_COLOR(POS_C), .NEG_COLOR(NEG_C), .AXIS_COLOR(AXIS_C), .BG_COLOR(BG_C)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .frame_start (frame_start),
        .wif         (wif.slave),
        .out_color   (out_color)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] c;
        bit          chk;
        int          x;
        int          y;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   act[NB];
    int   shd[NB];
    int   wbuf[NB];
    bit   m_pending = 1'b0;
    bit   synced    = 1'b0;
    bit   started   = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [11:0] ref_color(input int x, input int y);
        logic [11:0] c;
        int v, h, k, off;
        bit inreg;
        c = BG_C;
        inreg = synced && (x >= X0) && (x < X0 + NB*P);
        if (inreg && y == BASE) c = AXIS_C;
        if (inreg) begin
            k   = (x - X0) / P;
            off = (x - X0) % P;
            if (off < BW) begin
                v = act[k];
                h = (v < 0) ? -v : v;
                if (h > MAXH) h = MAXH;
                if (v > 0 && y >= BASE - h && y < BASE) c = POS_C;
                if (v < 0 && y > BASE && y <= BASE + h) c = NEG_C;
            end
        end
        return c;
    endfunction

    // Reference model: bank/handshake behaviour and the expected pixel for each sampled coordinate.
    always @(posedge clock) begin
        exp_t e;
        logic signed [VW-1:0] tmp;
        started = 1'b1;
        e.x = counter_x;
        e.y = counter_y;
        if (reset) begin
            for (int k = 0; k < NB; k++) begin
                act[k] = 0;
                shd[k] = 0;
            end
            m_pending = 1'b0;
            synced    = 1'b0;
            e.c   = '0;
            e.chk = 1'b0;
        end else begin
            if (frame_start && m_pending) begin
                for (int k = 0; k < NB; k++) act[k] = shd[k];
                m_pending = 1'b0;
            end else if (wif.weights_valid && !m_pending) begin
                for (int k = 0; k < NB; k++) begin
                    tmp    = wif.weights_flat[k*VW +: VW];
                    shd[k] = int'(tmp);
                end
                m_pending = 1'b1;
            end
            if (int'(counter_x) <= X0) synced = 1'b1;
            e.c   = ref_color(int'(counter_x), int'(counter_y));
            e.chk = 1'b1;
        end
        exp_q.push_back(e);
    end

    // Monitor: the output seen after edge N belongs to the coordinates sampled at edge N-2.
    always @(negedge clock) begin
        exp_t e;
        if (started) begin
            if (reset) begin
                check("reset_color", 32'(out_color), 32'd0);
                check("reset_ready", 32'(wif.weights_ready), 32'd1);
            end else begin
                check("ready", 32'(wif.weights_ready), 32'(!m_pending));
            end
            while (exp_q.size() > 2) begin
                e = exp_q.pop_front();
                if (!reset && e.chk) begin
                    check($sformatf("color x=%0d y=%0d", e.x, e.y), 32'(out_color), 32'(e.c));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NB*VW-1:0] pack_wbuf();
        logic [NB*VW-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) p[k*VW +: VW] = VW'(wbuf[k]);
        return p;
    endfunction

    function automatic int rand_w();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 511;
        if (r == 1) return -512;
        if (r == 2) return 0;
        return int'($urandom_range(0, 500)) - 250;
    endfunction

    task automatic rand_wbuf();
        for (int k = 0; k < NB; k++) wbuf[k] = rand_w();
    endtask

    task automatic load();
        wif.weights_flat  = pack_wbuf();
        counter_x = '0;
        counter_y = 10'd500;
        wif.weights_valid = 1'b1;
        step();
        wif.weights_valid = 1'b0;
    endtask

    task automatic frame(input bit with_load);
        if (with_load) wif.weights_flat = pack_wbuf();
        counter_x = '0;
        counter_y = 10'd500;
        frame_start = 1'b1;
        wif.weights_valid = with_load;
        step();
        frame_start = 1'b0;
        wif.weights_valid = 1'b0;
    endtask

    task automatic scan_line(input int y, input int load_x, input int rst_x);
        for (int x = 0; x < LINE; x++) begin
            counter_x = 10'(x);
            counter_y = 10'(y);
            wif.weights_valid = (x == load_x);
            if (x == rst_x) reset = 1'b1;
            if (rst_x >= 0 && x == rst_x + 4) reset = 1'b0;
            step();
        end
        wif.weights_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ylist[12];
        wif.weights_flat  = '0;
        wif.weights_valid = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        step();

        wbuf[0] = 50;  wbuf[1] = 0;    wbuf[2] = -30; wbuf[3] = 511;
        wbuf[4] = -512; wbuf[5] = 37;  wbuf[6] = -1;  wbuf[7] = 200;
        load();
        check("ready_after_load", 32'(wif.weights_ready), 32'd0);
        frame(1'b0);
        check("ready_after_swap", 32'(wif.weights_ready), 32'd1);
        ylist = '{200, 241, 271, 272, 41, 40, 441, 442, 191, 190, 240, 242};
        foreach (ylist[i]) scan_line(ylist[i], -1, -1);

        // Mid-frame transfer: display must hold the old bank until frame_start.
        rand_wbuf();
        wif.weights_flat = pack_wbuf();
        scan_line(150, 300, -1);
        check("ready_mid_frame", 32'(wif.weights_ready), 32'd0);
        scan_line(241, -1, -1);
        scan_line(260, -1, -1);
        frame(1'b0);
        check("ready_after_frame", 32'(wif.weights_ready), 32'd1);
        scan_line(150, -1, -1);
        scan_line(300, -1, -1);

        // frame_start coinciding with a load while nothing is pending.
        rand_wbuf();
        frame(1'b1);
        check("ready_same_cycle", 32'(wif.weights_ready), 32'd0);
        scan_line(120, -1, -1);
        scan_line(350, -1, -1);
        frame(1'b0);
        scan_line(120, -1, -1);
        scan_line(350, -1, -1);

        repeat (6) begin
            rand_wbuf();
            load();
            frame(1'b0);
            repeat (3) scan_line(int'($urandom_range(30, 460)), -1, -1);
        end

        // Reset mid-line with a transfer pending: all banks must come back empty.
        rand_wbuf();
        load();
        scan_line(241, -1, 300);
        check("ready_after_reset", 32'(wif.weights_ready), 32'd1);
        frame(1'b0);
        scan_line(241, -1, -1);
        scan_line(200, -1, -1);
        scan_line(300, -1, -1);

        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
